// File: rtl/spi_slave_byte_if.sv
// spi_slave_byte_if: SPI mode-0 slave byte front end. Synchronises the raw pins, deserialises
// MOSI into words with a valid strobe and serialises words from a valid/ready source onto MISO.
`default_nettype none

module spi_slave_byte_if #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MOSI,
  input  logic              SCK,
  input  logic              nSS,
  output logic              MISO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sck_sync;
  logic [SYNC_STAGES-1:0]  nss_sync;
  logic [SYNC_STAGES-1:0]  mosi_sync;
  logic                    sck_hist;
  logic                    nss_hist;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    byte_done;
  logic                    rx_hit;
  logic [DATA_W-2:0]       rx_shift;
  logic [DATA_W-1:0]       tx_shift;

  logic              sck_s, nss_s, mosi_s;
  logic              sck_rise, sck_fall, nss_rise, nss_fall;
  logic              tx_load;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] load_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync  <= '0;
      nss_sync  <= '1;
      mosi_sync <= '0;
      sck_hist  <= 1'b0;
      nss_hist  <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      nss_sync  <= {nss_sync[SYNC_STAGES-2:0], nSS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_hist  <= sck_sync[SYNC_STAGES-1];
      nss_hist  <= nss_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign nss_s    = nss_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_hist;
  assign sck_fall = ~sck_s & sck_hist;
  assign nss_rise = nss_s & ~nss_hist;
  assign nss_fall = ~nss_s & nss_hist;
  assign rx_next  = {rx_shift, mosi_s};

  // Handshake is combinational so tx_data is consumed on the same edge that tx_ready is seen high.
  assign tx_load     = ((state == IDLE) && nss_fall) ||
                       ((state == ACTIVE) && !nss_rise && sck_fall && byte_done);
  assign tx_ready    = tx_load & tx_valid;
  assign tx_underrun = tx_load & ~tx_valid;
  assign load_word   = tx_valid ? tx_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      byte_done   <= 1'b0;
      rx_hit      <= 1'b0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_shift    <= '0;
      MISO        <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      rx_hit      <= 1'b0;
      rx_valid    <= rx_hit;
      MISO        <= (state == ACTIVE) & tx_shift[DATA_W-1];
      case (state)
        IDLE: begin
          if (nss_fall) begin
            state       <= ACTIVE;
            busy        <= 1'b1;
            frame_start <= 1'b1;
            bit_cnt     <= '0;
            byte_done   <= 1'b0;
            tx_shift    <= load_word;
          end
        end
        ACTIVE: begin
          // A frame end wins over any SCK edge seen in the same cycle.
          if (nss_rise) begin
            state     <= IDLE;
            busy      <= 1'b0;
            frame_end <= 1'b1;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
          end else if (sck_rise) begin
            rx_shift <= rx_next[DATA_W-2:0];
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              rx_data   <= rx_next;
              rx_hit    <= 1'b1;
              bit_cnt   <= '0;
              byte_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sck_fall) begin
            if (byte_done) begin
              tx_shift  <= load_word;
              byte_done <= 1'b0;
            end else begin
              tx_shift <= tx_shift << 1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_byte_if.sv
// tb_spi_slave_byte_if: drives SPI frames as a master and checks every output each cycle
// against a word-level model fed with the pin samples delayed by the synchroniser depth.
`default_nettype none
`timescale 1ns/1ps

module tb_spi_slave_byte_if;

  localparam int DW = 8;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          MOSI = 1'b0, SCK = 1'b0, nSS = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          MISO, rx_valid, tx_ready, tx_underrun, frame_start, frame_end, busy;
  logic [DW-1:0] rx_data;

  always #5 clk = ~clk;

  spi_slave_byte_if #(.DATA_W(DW), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .MOSI(MOSI), .SCK(SCK), .nSS(nSS), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .frame_start(frame_start),
    .frame_end(frame_end), .busy(busy)
  );

  int vectors = 0, miscompares = 0;

  // Model: pin samples per clk edge, delayed by the synchroniser depth.
  bit q_sck[$], q_nss[$], q_mosi[$];
  bit m_active, m_byte_done, m_rx_done, m_rxv, m_fs, m_fe, m_miso;
  int m_bitcnt, m_idx;
  logic [DW-1:0] m_rx_acc, m_rx_data, m_tx_word;
  logic [DW-1:0] txq[$];
  bit rand_valid = 0;

  int n_ready, n_under, n_rxv, n_fs, n_fe, n_busy, n_miso1;
  logic [DW-1:0] rx_seen[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_sck.delete(); q_nss.delete(); q_mosi.delete();
    for (int i = 0; i <= S; i++) begin
      q_sck.push_back(1'b0); q_nss.push_back(1'b1); q_mosi.push_back(1'b0);
    end
    m_active = 0; m_byte_done = 0; m_rx_done = 0; m_rxv = 0; m_fs = 0; m_fe = 0; m_miso = 0;
    m_bitcnt = 0; m_idx = 0; m_rx_acc = '0; m_rx_data = '0; m_tx_word = '0;
  endtask

  function automatic bit pending_load();
    bit nfall, nrise, sfall;
    nfall = !q_nss[1] && q_nss[0];
    nrise = q_nss[1] && !q_nss[0];
    sfall = !q_sck[1] && q_sck[0];
    return (!m_active && nfall) || (m_active && !nrise && sfall && m_byte_done);
  endfunction

  function automatic bit tx_bit();
    return (m_idx < DW) ? m_tx_word[DW-1-m_idx] : 1'b0;
  endfunction

  task automatic load_word();
    if (tx_valid) begin
      m_tx_word = tx_data;
      void'(txq.pop_front());
    end else begin
      m_tx_word = '0;
    end
    m_idx = 0;
  endtask

  task automatic model_edge();
    bit sn, hn, ss, hs, ms;
    sn = q_nss[1]; hn = q_nss[0]; ss = q_sck[1]; hs = q_sck[0]; ms = q_mosi[1];
    m_miso = m_active ? tx_bit() : 1'b0;
    m_rxv = m_rx_done; m_rx_done = 0; m_fs = 0; m_fe = 0;
    if (!m_active) begin
      if (!sn && hn) begin
        m_active = 1; m_fs = 1; m_bitcnt = 0; m_byte_done = 0; load_word();
      end
    end else if (sn && !hn) begin
      m_active = 0; m_fe = 1; m_bitcnt = 0; m_byte_done = 0;
    end else if (ss && !hs) begin
      m_rx_acc = {m_rx_acc[DW-2:0], ms};
      m_bitcnt++;
      if (m_bitcnt == DW) begin
        m_rx_data = m_rx_acc; m_rx_done = 1; m_bitcnt = 0; m_byte_done = 1;
      end
    end else if (!ss && hs) begin
      if (m_byte_done) begin load_word(); m_byte_done = 0; end
      else m_idx++;
    end
    void'(q_sck.pop_front()); void'(q_nss.pop_front()); void'(q_mosi.pop_front());
    q_sck.push_back(SCK); q_nss.push_back(nSS); q_mosi.push_back(MOSI);
  endtask

  task automatic compare();
    bit pl;
    pl = pending_load();
    check("MISO", MISO, m_miso);
    check("rx_valid", rx_valid, m_rxv);
    check("rx_data", rx_data, m_rx_data);
    check("frame_start", frame_start, m_fs);
    check("frame_end", frame_end, m_fe);
    check("busy", busy, m_active);
    check("tx_ready", tx_ready, pl & tx_valid);
    check("tx_underrun", tx_underrun, pl & ~tx_valid);
    if (tx_ready === 1'b1) n_ready++;
    if (tx_underrun === 1'b1) n_under++;
    if (frame_start === 1'b1) n_fs++;
    if (frame_end === 1'b1) n_fe++;
    if (busy === 1'b1) n_busy++;
    if (MISO === 1'b1) n_miso1++;
    if (rx_valid === 1'b1) begin n_rxv++; rx_seen.push_back(rx_data); end
  endtask

  task automatic drive_tx();
    if (txq.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
      tx_valid = 1'b1; tx_data = txq[0];
    end else begin
      tx_valid = 1'b0; tx_data = DW'($urandom);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    if (reset) model_edge(); else model_reset();
    #1;
    drive_tx();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic clr();
    n_ready = 0; n_under = 0; n_rxv = 0; n_fs = 0; n_fe = 0; n_busy = 0; n_miso1 = 0;
    rx_seen.delete();
  endtask

  task automatic start_frame();
    nSS = 1'b0;
    wait_cycles(6);
  endtask

  // Mode 0 master: MOSI set while SCK low, MISO captured at the moment SCK rises.
  task automatic send_bits(input logic [DW-1:0] b, input int nbits, input int hp,
                           input bit last, output logic [DW-1:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = b[DW-1-i];
      wait_cycles(hp);
      rd[DW-1-i] = MISO;
      SCK = 1'b1;
      wait_cycles(hp);
      if (i < nbits - 1 || !last) SCK = 1'b0;
    end
  endtask

  task automatic end_frame();
    SCK = 1'b0; nSS = 1'b1;
    wait_cycles(8);
  endtask

  initial begin
    logic [DW-1:0] rd0, rd1, rd2, b;
    int nw, hp, ab, nk;
    bit lst;

    model_reset();
    clr();
    wait_cycles(3);
    check("rst_MISO", MISO, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    reset = 1'b1;
    wait_cycles(4);

    // Single word
    clr(); txq.push_back(8'h3C); drive_tx();
    start_frame();
    send_bits(8'hA5, 8, 4, 1, rd0);
    end_frame();
    check("t1_read", rd0, 8'h3C);
    check("t1_ready_cnt", n_ready, 1);
    check("t1_under_cnt", n_under, 0);
    check("t1_rxv_cnt", n_rxv, 1);
    check("t1_rx_data", rx_data, 8'hA5);
    check("t1_model_rx", m_rx_data, 8'hA5);
    check("t1_fs_cnt", n_fs, 1);
    check("t1_fe_cnt", n_fe, 1);

    // Three-word burst
    clr(); txq.push_back(8'h11); txq.push_back(8'h22); txq.push_back(8'h33); drive_tx();
    start_frame();
    send_bits(8'h01, 8, 4, 0, rd0);
    send_bits(8'h80, 8, 4, 0, rd1);
    send_bits(8'hFF, 8, 4, 1, rd2);
    end_frame();
    check("t2_read0", rd0, 8'h11);
    check("t2_read1", rd1, 8'h22);
    check("t2_read2", rd2, 8'h33);
    check("t2_rxv_cnt", n_rxv, 3);
    check("t2_rx0", (rx_seen.size() > 0) ? rx_seen[0] : 8'hxx, 8'h01);
    check("t2_rx1", (rx_seen.size() > 1) ? rx_seen[1] : 8'hxx, 8'h80);
    check("t2_rx2", (rx_seen.size() > 2) ? rx_seen[2] : 8'hxx, 8'hFF);
    check("t2_ready_cnt", n_ready, 3);
    check("t2_under_cnt", n_under, 0);

    // Underrun
    clr();
    start_frame();
    send_bits(8'($urandom), 8, 4, 0, rd0);
    send_bits(8'($urandom), 8, 4, 1, rd1);
    end_frame();
    check("t3_read0", rd0, 8'h00);
    check("t3_read1", rd1, 8'h00);
    check("t3_miso_ones", n_miso1, 0);
    check("t3_under_cnt", n_under, 2);
    check("t3_ready_cnt", n_ready, 0);

    // Abort after five bits, then a clean word
    clr();
    start_frame();
    send_bits(8'hF0, 5, 4, 0, rd0);
    wait_cycles(4);
    end_frame();
    check("t4_rxv_cnt", n_rxv, 0);
    check("t4_fe_cnt", n_fe, 1);
    clr();
    start_frame();
    send_bits(8'h5A, 8, 4, 1, rd0);
    end_frame();
    check("t4_rx_data", (rx_seen.size() > 0) ? rx_seen[0] : 8'hxx, 8'h5A);

    // Reset mid-frame
    txq.push_back(8'h77); drive_tx();
    start_frame();
    send_bits(8'hFF, 3, 4, 0, rd0);
    reset = 1'b0; nSS = 1'b1; SCK = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_rst_MISO", MISO, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_rx_data", rx_data, 0);
      check("t5_rst_ready", tx_ready, 0);
    end
    reset = 1'b1;
    wait_cycles(6);
    clr();
    start_frame();
    send_bits(8'hC3, 8, 4, 1, rd0);
    end_frame();
    check("t5_rx_data", (rx_seen.size() > 0) ? rx_seen[0] : 8'hxx, 8'hC3);
    check("t5_rxv_cnt", n_rxv, 1);

    // SCK glitches while deselected
    clr();
    for (int i = 0; i < 40; i++) begin
      SCK = 1'($urandom); MOSI = 1'($urandom);
      tick();
    end
    SCK = 1'b0;
    wait_cycles(6);
    check("t6_rxv_cnt", n_rxv, 0);
    check("t6_busy_cnt", n_busy, 0);
    check("t6_miso_ones", n_miso1, 0);

    // Randomised frames
    rand_valid = 1;
    for (int f = 0; f < 20; f++) begin
      nw = $urandom_range(1, 3);
      hp = $urandom_range(4, 6);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      nk = $urandom_range(0, 4);
      for (int k = 0; k < nk; k++) txq.push_back(8'($urandom));
      start_frame();
      for (int w = 0; w < nw; w++) begin
        b = 8'($urandom);
        lst = (w == nw - 1) && ($urandom_range(0, 1) == 1);
        if (w == nw - 1 && ab != 0) send_bits(b, ab, hp, 0, rd0);
        else send_bits(b, 8, hp, lst, rd0);
      end
      wait_cycles(hp);
      end_frame();
      wait_cycles($urandom_range(0, 5));
    end
    rand_valid = 0;
    wait_cycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
